// File: rtl/path_scan_pkg.sv
// rtl/path_scan_pkg.sv - shared constants and state encoding for the path scan sequencer
package path_scan_pkg;

  localparam int NUM_PATHS = 16;
  localparam int SEL_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/path_next_find.sv
// rtl/path_next_find.sv - priority encoder: next enabled channel above cur, and lowest enabled channel
module path_next_find
  import path_scan_pkg::*;
(
  input  logic [NUM_PATHS-1:0] mask,
  input  logic [SEL_W-1:0]     cur,
  output logic [SEL_W-1:0]     nxt,
  output logic                 found,
  output logic [SEL_W-1:0]     lowest
);

  // Scan from the top down so the lowest qualifying index is the last one written.
  always_comb begin
    nxt    = '0;
    found  = 1'b0;
    lowest = '0;
    for (int i = NUM_PATHS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = SEL_W'(i);
        if (SEL_W'(i) > cur) begin
          nxt   = SEL_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/path_scan_seq.sv
// rtl/path_scan_seq.sv - masked channel scan sequencer driving the 4-to-16 path selector
// Optional SCAN_BLANK_EN inserts a break-before-make BLANK cycle on every channel change.
module path_scan_seq
  import path_scan_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 continuous,
  input  logic [NUM_PATHS-1:0] mask_in,
  input  logic [DW-1:0]        dwell_in,
  output logic [SEL_W-1:0]     select,
  output logic                 sel_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 wrap
);

  state_t               state_q, state_d;
  logic [NUM_PATHS-1:0] mask_q, mask_d;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [DW-1:0]        cnt_q, cnt_d;
  logic                 cont_q, cont_d;
  logic [SEL_W-1:0]     select_d;
  logic                 sel_valid_d, busy_d, done_d, wrap_d;

  logic [NUM_PATHS-1:0] find_mask;
  logic [SEL_W-1:0]     nxt_idx, low_idx;
  logic                 nxt_found;

  // While idle the first channel must come from the live mask, not the stale latched one.
  assign find_mask = (state_q == ST_IDLE) ? mask_in : mask_q;

  path_next_find u_find (
    .mask   (find_mask),
    .cur    (select),
    .nxt    (nxt_idx),
    .found  (nxt_found),
    .lowest (low_idx)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      cont_q    <= 1'b0;
      select    <= '0;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      cont_q    <= cont_d;
      select    <= select_d;
      sel_valid <= sel_valid_d;
      busy      <= busy_d;
      done      <= done_d;
      wrap      <= wrap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    cont_d      = cont_q;
    select_d    = select;
    sel_valid_d = sel_valid;
    busy_d      = busy;
    done_d      = 1'b0;
    wrap_d      = 1'b0;

    if (stop) begin
      state_d     = ST_IDLE;
      sel_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mask_d  = mask_in;
            dwell_d = dwell_in;
            cont_d  = continuous;
            if (mask_in == '0) begin
              done_d = 1'b1;
            end else begin
              select_d    = low_idx;
              sel_valid_d = 1'b1;
              busy_d      = 1'b1;
              cnt_d       = dwell_in;
              state_d     = ST_DWELL;
            end
          end
        end

        ST_DWELL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DW'(1);
          end else if (!nxt_found && !cont_q) begin
            state_d     = ST_IDLE;
            sel_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
`ifdef SCAN_BLANK_EN
            state_d     = ST_BLANK;
            sel_valid_d = 1'b0;
`else
            cnt_d = dwell_q;
            if (nxt_found) begin
              select_d = nxt_idx;
            end else begin
              select_d = low_idx;
              wrap_d   = 1'b1;
            end
`endif
          end
        end

`ifdef SCAN_BLANK_EN
        // select still holds the old channel here, so the finder result is still valid.
        ST_BLANK: begin
          state_d     = ST_DWELL;
          sel_valid_d = 1'b1;
          cnt_d       = dwell_q;
          if (nxt_found) begin
            select_d = nxt_idx;
          end else begin
            select_d = low_idx;
            wrap_d   = 1'b1;
          end
        end
`endif

        default: begin
          state_d     = ST_IDLE;
          sel_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_scan_seq.sv
// tb/tb_path_scan_seq.sv - directed self-checking bench for path_scan_seq
module tb_path_scan_seq;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        continuous;
  logic [15:0] mask_in;
  logic [7:0]  dwell_in;
  logic [3:0]  select;
  logic        sel_valid;
  logic        busy;
  logic        done;
  logic        wrap;

  int checks   = 0;
  int failures = 0;

  path_scan_seq #(.DW(8)) dut (
    .clk1       (clk1),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .mask_in    (mask_in),
    .dwell_in   (dwell_in),
    .select     (select),
    .sel_valid  (sel_valid),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mk(input logic [3:0] s, input logic v, input logic b,
                                    input logic d, input logic w);
    return {s, v, b, d, w};
  endfunction

  function automatic logic [7:0] obs();
    return {select, sel_valid, busy, done, wrap};
  endfunction

  function automatic logic [7:0] flags();
    return {4'h0, sel_valid, busy, done, wrap};
  endfunction

  task automatic pulse_start(input logic [15:0] m, input logic [7:0] d, input logic c);
    mask_in    = m;
    dwell_in   = d;
    continuous = c;
    start      = 1'b1;
    @(negedge clk1);
    start      = 1'b0;
  endtask

  initial begin
    logic [3:0] s;
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    continuous = 1'b0;
    mask_in    = '0;
    dwell_in   = '0;
    repeat (2) @(negedge clk1);
    chk("reset", obs(), 8'h00);
    rst = 1'b0;
    @(negedge clk1);
    chk("idle", obs(), 8'h00);

    // Empty mask: single done pulse, nothing else moves
    pulse_start(16'h0000, 8'd3, 1'b0);
    chk("empty_done", flags(), mk(4'h0, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk1);
    chk("empty_after", flags(), 8'h00);

    // start and stop together in IDLE: stop wins
    stop = 1'b1;
    pulse_start(16'h0001, 8'd0, 1'b0);
    stop = 1'b0;
    chk("stopstart", flags(), 8'h00);
    @(negedge clk1);
    chk("stopstart2", flags(), 8'h00);

`ifdef SCAN_BLANK_EN
    pulse_start(16'h0003, 8'd1, 1'b0);
    for (int t = 0; t < 5; t++) begin
      s = (t < 3) ? 4'd0 : 4'd1;
      chk($sformatf("blank_t%0d", t), obs(), mk(s, (t != 2), 1'b1, 1'b0, 1'b0));
      @(negedge clk1);
    end
    chk("blank_done", obs(), mk(4'd1, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk1);
    chk("blank_after", obs(), mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0));
`else
    // One-shot pass, mask 0x0025, dwell 2
    pulse_start(16'h0025, 8'd2, 1'b0);
    for (int t = 0; t < 9; t++) begin
      s = (t < 3) ? 4'd0 : (t < 6) ? 4'd2 : 4'd5;
      chk($sformatf("pass_t%0d", t), obs(), mk(s, 1'b1, 1'b1, 1'b0, 1'b0));
      @(negedge clk1);
    end
    chk("pass_done", obs(), mk(4'd5, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk1);
    chk("pass_after", obs(), mk(4'd5, 1'b0, 1'b0, 1'b0, 1'b0));

    // Continuous, mask 0x8001, dwell 0
    pulse_start(16'h8001, 8'd0, 1'b1);
    for (int t = 0; t < 8; t++) begin
      s = (t % 2 == 1) ? 4'd15 : 4'd0;
      chk($sformatf("cont_t%0d", t), obs(), mk(s, 1'b1, 1'b1, 1'b0, (t != 0) && (t % 2 == 0)));
      @(negedge clk1);
    end
    stop = 1'b1;
    @(negedge clk1);
    stop = 1'b0;
    chk("cont_stop", flags(), 8'h00);

    // start mid-scan with a different setup is ignored
    pulse_start(16'h0024, 8'd1, 1'b0);
    for (int t = 0; t < 4; t++) begin
      s = (t < 2) ? 4'd2 : 4'd5;
      chk($sformatf("ign_t%0d", t), obs(), mk(s, 1'b1, 1'b1, 1'b0, 1'b0));
      if (t == 1) begin
        mask_in    = 16'h0001;
        dwell_in   = 8'd0;
        continuous = 1'b1;
        start      = 1'b1;
      end
      @(negedge clk1);
      start = 1'b0;
    end
    chk("ign_done", obs(), mk(4'd5, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk1);

    // Abort during the second channel
    pulse_start(16'h0007, 8'd2, 1'b0);
    for (int t = 0; t < 4; t++) begin
      s = (t < 3) ? 4'd0 : 4'd1;
      chk($sformatf("abort_t%0d", t), obs(), mk(s, 1'b1, 1'b1, 1'b0, 1'b0));
      if (t < 3) @(negedge clk1);
    end
    stop = 1'b1;
    @(negedge clk1);
    stop = 1'b0;
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("abort_idle%0d", t), flags(), 8'h00);
      @(negedge clk1);
    end
`endif

    // Reset in the middle of a continuous scan, then restart
    pulse_start(16'h0030, 8'd1, 1'b1);
    for (int t = 0; t < 3; t++) begin
      s = (t < 2) ? 4'd4 : 4'd5;
      chk($sformatf("rstmid_t%0d", t), obs(), mk(s, 1'b1, 1'b1, 1'b0, 1'b0));
      if (t < 2) @(negedge clk1);
    end
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    chk("rstmid_zero", obs(), 8'h00);
    pulse_start(16'h0030, 8'd1, 1'b1);
    chk("rstmid_restart", obs(), mk(4'd4, 1'b1, 1'b1, 1'b0, 1'b0));
    stop = 1'b1;
    @(negedge clk1);
    stop = 1'b0;
    chk("final_stop", flags(), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
